// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator and its address decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        UNMAP  = 2'd3
    } apb_state_e;

    localparam int NUM_SLV         = 4;
    localparam int SLV_REGION_BITS = 12;   // 4 KB per slave
    localparam int SLV_IDX_W       = 2;

endpackage

// File: rtl/apb_addr_decoder.sv
// Peripheral window decoder: maps a byte address to hit, one-hot select and slave index.
// Latency: combinational.
// Backpressure: none.
// Ports: page   - address bits above the 4 KB slave region offset
//        hit    - address falls inside one of the mapped slave regions
//        sel    - one-hot slave select (all zero on a miss)
//        idx    - binary slave index
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic [31-SLV_REGION_BITS:0] page,
    output logic                        hit,
    output logic [NUM_SLV-1:0]          sel,
    output logic [SLV_IDX_W-1:0]        idx
);

    // page[19:4] = addr[31:16], page[3:2] = addr[15:14], page[1:0] = addr[13:12]
    assign idx = page[SLV_IDX_W-1:0];
    assign hit = (page[31-SLV_REGION_BITS:16-SLV_REGION_BITS] == BASE_ADDR[31:16]) &&
                 (page[15-SLV_REGION_BITS:SLV_IDX_W] == '0);
    assign sel = hit ? (NUM_SLV'(1) << idx) : '0;

endmodule

// File: rtl/apb_master_bridge.sv
// CPU request/ready port to APB initiator for four slaves, with a wait-state timeout.
// Latency: ready 3 cycles after the request for a zero-wait slave, 2 for an unmapped address.
// Backpressure: requests are taken only in IDLE; slaves stall via PREADY up to TIMEOUT ACCESS cycles.
// Ports: CPU side  - transfer/write/addr/wdata in, rdata/ready/err out
//        APB side  - PADDR/PWRITE/PWDATA/PENABLE/PSEL out, PRDATA0..3/PREADY0..3 in
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               transfer,
    input  logic               write,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic               err,
    output logic [31:0]        PADDR,
    output logic               PWRITE,
    output logic [31:0]        PWDATA,
    output logic               PENABLE,
    output logic [NUM_SLV-1:0] PSEL,
    input  logic [31:0]        PRDATA0,
    input  logic [31:0]        PRDATA1,
    input  logic [31:0]        PRDATA2,
    input  logic [31:0]        PRDATA3,
    input  logic               PREADY0,
    input  logic               PREADY1,
    input  logic               PREADY2,
    input  logic               PREADY3
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    apb_state_e             state, state_nxt;
    logic                   dec_hit;
    logic [NUM_SLV-1:0]     dec_sel;
    logic [SLV_IDX_W-1:0]   dec_idx;
    logic [NUM_SLV-1:0]     sel_q;
    logic [SLV_IDX_W-1:0]   idx_q;
    logic [CW-1:0]          wait_cnt;
    logic                   slv_ready;
    logic [31:0]            slv_rdata;
    logic                   timeout_hit;

    apb_addr_decoder #(.BASE_ADDR(BASE_ADDR)) u_dec (
        .page (addr[31:SLV_REGION_BITS]),
        .hit  (dec_hit),
        .sel  (dec_sel),
        .idx  (dec_idx)
    );

    // Only the latched slave's response is looked at; others may be X.
    always_comb begin
        slv_ready = 1'b0;
        slv_rdata = '0;
        case (idx_q)
            2'd0: begin slv_ready = PREADY0; slv_rdata = PRDATA0; end
            2'd1: begin slv_ready = PREADY1; slv_rdata = PRDATA1; end
            2'd2: begin slv_ready = PREADY2; slv_rdata = PRDATA2; end
            default: begin slv_ready = PREADY3; slv_rdata = PRDATA3; end
        endcase
    end

    assign timeout_hit = (wait_cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (transfer) state_nxt = dec_hit ? SETUP : UNMAP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (slv_ready || timeout_hit) state_nxt = IDLE;
            UNMAP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR    <= '0;
            PWRITE   <= 1'b0;
            PWDATA   <= '0;
            sel_q    <= '0;
            idx_q    <= '0;
            wait_cnt <= '0;
            rdata    <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
        end else begin
            // ready/err are single-cycle completion pulses
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (transfer && dec_hit) begin
                        PADDR  <= addr;
                        PWRITE <= write;
                        PWDATA <= wdata;
                        sel_q  <= dec_sel;
                        idx_q  <= dec_idx;
                    end
                end
                SETUP: wait_cnt <= '0;
                ACCESS: begin
                    if (slv_ready) begin
                        ready <= 1'b1;
                        if (!PWRITE) rdata <= slv_rdata;
                    end else if (timeout_hit) begin
                        ready <= 1'b1;
                        err   <= 1'b1;
                        rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                UNMAP: begin
                    ready <= 1'b1;
                    err   <= 1'b1;
                    rdata <= '0;
                end
                default: ;
            endcase
        end
    end

    // Decoded from registered state only, so the bus strobes cannot glitch.
    assign PSEL    = (state == SETUP || state == ACCESS) ? sel_q : '0;
    assign PENABLE = (state == ACCESS);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed vector table, random traffic, reset abort.
// Latency: n/a.
// Backpressure: bench slave model inserts a per-transaction number of wait states.
module tb_apb_master_bridge;

    localparam int TIMEOUT = 16;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        transfer = 1'b0;
    logic        write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PENABLE;
    logic [3:0]  PSEL;
    logic [31:0] prd [4];
    logic        prdy [4];

    int checks = 0;
    int errors = 0;
    logic [31:0] m_rdata = '0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge #(.BASE_ADDR(32'h1000_0000), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
        .PRDATA0(prd[0]), .PRDATA1(prd[1]), .PRDATA2(prd[2]), .PRDATA3(prd[3]),
        .PREADY0(prdy[0]), .PREADY1(prdy[1]), .PREADY2(prdy[2]), .PREADY3(prdy[3])
    );

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] pr;
        int          wait_n;
        bit          noise;
        bit          chain;
        int          exp_lat;
        bit          exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference address map: 64 KB window at 0x1000xxxx, lower 16 KB split into 4 KB slaves.
    function automatic bit m_hit(input logic [31:0] a);
        return ((a >> 16) == 32'h1000) && (((a >> 14) & 32'h3) == 0);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> 12) & 32'h3);
    endfunction

    function automatic int m_lat(input logic [31:0] a, input int wait_n);
        if (!m_hit(a))          return 2;
        if (wait_n < TIMEOUT)   return 3 + wait_n;
        return 2 + TIMEOUT;
    endfunction

    function automatic bit m_err(input logic [31:0] a, input int wait_n);
        return !m_hit(a) || (wait_n >= TIMEOUT);
    endfunction

    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] pr, input int wait_n, input bit noise,
                           input bit chain, input int exp_lat, input bit exp_err);
        int       lat;
        int       pen_cnt;
        int       exp_pen;
        int       k;
        bit       done;
        bit       bad_psel;
        bit       bad_bus;
        logic [3:0] exp_sel;
        logic [3:0] one;
        one      = 4'b0001;
        exp_sel  = m_hit(a) ? (one << m_idx(a)) : 4'b0000;
        k        = m_idx(a);
        lat      = -1;
        pen_cnt  = 0;
        done     = 1'b0;
        bad_psel = 1'b0;
        bad_bus  = 1'b0;
        if (!chain) begin
            @(negedge PCLK);
            chk("ready_low_between", {31'd0, ready}, 32'd0);
        end
        transfer = 1'b1;
        write    = wr;
        addr     = a;
        wdata    = wd;
        for (int i = 0; i < 4; i++) begin
            prdy[i] = 1'($urandom);
            prd[i]  = $urandom;
        end
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge PCLK);
            transfer = 1'b0;
            if (PSEL != 4'b0000 && PSEL != exp_sel) bad_psel = 1'b1;
            if (PSEL != 4'b0000 && (PADDR != a || PWRITE != wr || PWDATA != wd)) bad_bus = 1'b1;
            if (ready) begin
                done = 1'b1;
                lat  = cyc;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    prdy[i] = 1'($urandom);
                    prd[i]  = $urandom;
                end
                if (PENABLE && exp_sel != 4'b0000) begin
                    prdy[k] = (pen_cnt == wait_n);
                    if (pen_cnt == wait_n) prd[k] = pr;
                    pen_cnt++;
                end
                if (noise && (PENABLE || PSEL != 4'b0000)) begin
                    transfer = 1'($urandom);
                    write    = 1'($urandom);
                    addr     = $urandom;
                    wdata    = $urandom;
                end
            end
        end
        if (exp_err)  m_rdata = '0;
        else if (!wr) m_rdata = pr;
        exp_pen = (exp_sel == 4'b0000) ? 0 : (exp_err ? TIMEOUT : wait_n + 1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("err", {31'd0, err}, {31'd0, exp_err});
        chk("rdata", rdata, m_rdata);
        chk("penable_cycles", 32'(pen_cnt), 32'(exp_pen));
        chk("psel_onehot", {31'd0, bad_psel}, 32'd0);
        chk("bus_stable", {31'd0, bad_bus}, 32'd0);
        chk("psel_idle_at_ready", {28'd0, PSEL}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            prdy[i] = 1'b0;
            prd[i]  = '0;
        end
        //         wr    addr            wdata          prdata         wait  noise chain lat err
        vecs[0] = '{1'b1, 32'h1000_1008, 32'h0000_00A5, 32'h0,         1,    1'b0, 1'b0, 4,  1'b0};
        vecs[1] = '{1'b0, 32'h1000_0004, 32'h0,         32'h1234_5678, 0,    1'b0, 1'b0, 3,  1'b0};
        vecs[2] = '{1'b0, 32'h2000_0000, 32'h0,         32'h0,         0,    1'b0, 1'b0, 2,  1'b1};
        vecs[3] = '{1'b0, 32'h1000_3000, 32'h0,         32'h0,         1000, 1'b0, 1'b0, 18, 1'b1};
        vecs[4] = '{1'b1, 32'h1000_2010, 32'h5A5A_0001, 32'h0,         2,    1'b1, 1'b0, 5,  1'b0};
        vecs[5] = '{1'b0, 32'h1000_2014, 32'h0,         32'hCAFE_F00D, 0,    1'b0, 1'b1, 3,  1'b0};
        vecs[6] = '{1'b0, 32'h1000_4000, 32'h0,         32'h0,         0,    1'b0, 1'b0, 2,  1'b1};
        vecs[7] = '{1'b0, 32'h1000_3FFC, 32'h0,         32'h8765_4321, 15,   1'b1, 1'b0, 18, 1'b0};
        vecs[8] = '{1'b1, 32'h1001_0000, 32'h1111_2222, 32'h0,         0,    1'b0, 1'b1, 2,  1'b1};
        vecs[9] = '{1'b0, 32'h1000_1FF0, 32'h0,         32'hDEAD_BEEF, 16,   1'b0, 1'b0, 18, 1'b1};

        // reset state
        #1;
        chk("rst_psel", {28'd0, PSEL}, 32'd0);
        chk("rst_penable", {31'd0, PENABLE}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_pwrite", {31'd0, PWRITE}, 32'd0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;

        for (int v = 0; v < 10; v++)
            run_txn(vecs[v].wr, vecs[v].a, vecs[v].wd, vecs[v].pr, vecs[v].wait_n,
                    vecs[v].noise, vecs[v].chain, vecs[v].exp_lat, vecs[v].exp_err);

        // reset while a read to slave1 sits in ACCESS
        @(negedge PCLK);
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_1100;
        for (int i = 0; i < 4; i++) prdy[i] = 1'b0;
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        chk("pre_rst_penable", {31'd0, PENABLE}, 32'd1);
        chk("pre_rst_psel", {28'd0, PSEL}, 32'h2);
        #2 PRESET = 1'b1;
        #1;
        chk("abort_psel", {28'd0, PSEL}, 32'd0);
        chk("abort_penable", {31'd0, PENABLE}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd0);
        m_rdata = '0;
        chk("abort_rdata", rdata, m_rdata);
        @(negedge PCLK);
        PRESET = 1'b0;
        run_txn(1'b0, 32'h1000_1100, 32'h0, 32'h0BAD_F00D, 1, 1'b0, 1'b0, 4, 1'b0);

        // random traffic against the reference map
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra;
            int          rw;
            if ($urandom_range(0, 4) == 0) ra = $urandom;
            else ra = {16'h1000, 2'b00, 2'($urandom), 12'($urandom)};
            rw = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
            run_txn(1'($urandom), ra, $urandom, $urandom, rw, 1'($urandom),
                    1'($urandom), m_lat(ra, rw), m_err(ra, rw));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
